// File: rtl/sc_frame_sng_pkg.sv
// Shared definitions for the stochastic-computing blocks: default widths,
// SNG state encoding and the counter-width helper.
package sc_pkg;

    localparam int SC_W     = 6;
    localparam int SC_FRAME = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sng_state_t;

    // One extra bit so a full frame of ones (== FRAME) fits without wrapping.
    function automatic int sc_cw(input int frame);
        return $clog2(frame) + 1;
    endfunction

endpackage

// File: rtl/sc_frame_sng_ones_counter.sv
// Per-frame ones accumulator and sample index, with clear/accumulate control
// and the frame-end flag used by the SNG state machine.
module sc_ones_counter
    import sc_pkg::*;
#(
    parameter int FRAME = SC_FRAME,
    parameter int CW    = sc_cw(FRAME)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          acc_i,
    input  logic          b_i,
    output logic [CW-1:0] sum_o,
    output logic          last_o
);

    localparam int IW = (FRAME > 1) ? $clog2(FRAME) : 1;

    logic [CW-1:0] ones_q, ones_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        ones_d = ones_q;
        idx_d  = idx_q;
        if (clr_i) begin
            ones_d = '0;
            idx_d  = '0;
        end else if (acc_i) begin
            ones_d = ones_q + CW'(b_i);
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q <= '0;
            idx_q  <= '0;
        end else begin
            ones_q <= ones_d;
            idx_q  <= idx_d;
        end
    end

    // Count including the current sample, so the frame total is ready on the last strobe.
    assign sum_o  = ones_q + CW'(b_i);
    assign last_o = (idx_q == IW'(FRAME - 1));

endmodule

// File: rtl/sc_frame_sng.sv
// Stochastic number generator: compares a per-frame operand against Sobol
// samples, emits one bit per sample and reports the frame's ones count.
module sc_frame_sng
    import sc_pkg::*;
#(
    parameter int W     = SC_W,
    parameter int FRAME = SC_FRAME,
    parameter int CW    = sc_cw(FRAME)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_in,
    input  logic [W-1:0]  x,
    input  logic          load,
    input  logic [W-1:0]  rnd,
    input  logic          rnd_valid,
    output logic          bit_out,
    output logic          bit_valid,
    output logic          busy,
    output logic [CW-1:0] result,
    output logic          result_valid
);

    sng_state_t    state_q;
    logic [W-1:0]  x_q;
    logic          bit_out_q;
    logic          bit_valid_q;
    logic          busy_q;
    logic [CW-1:0] result_q;
    logic          result_valid_q;

    logic          b;
    logic          sample;
    logic          cnt_clr;
    logic [CW-1:0] frame_sum;
    logic          frame_last;

    assign b       = (x_q > rnd);
    assign sample  = en_in && (state_q == RUN) && rnd_valid;
    assign cnt_clr = !en_in || ((state_q == IDLE) && load);

    sc_ones_counter #(
        .FRAME (FRAME),
        .CW    (CW)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .acc_i  (sample),
        .b_i    (b),
        .sum_o  (frame_sum),
        .last_o (frame_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            x_q            <= '0;
            bit_out_q      <= 1'b0;
            bit_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else if (!en_in) begin
            // Disable overrides any pending load; the last result stays readable.
            state_q        <= IDLE;
            bit_out_q      <= 1'b0;
            bit_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            bit_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        x_q     <= x;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (rnd_valid) begin
                        bit_out_q   <= b;
                        bit_valid_q <= 1'b1;
                        if (frame_last) begin
                            result_q       <= frame_sum;
                            result_valid_q <= 1'b1;
                            state_q        <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bit_out      = bit_out_q;
    assign bit_valid    = bit_valid_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sc_frame_sng.sv
// Directed bench for sc_frame_sng: expected bits/results are queued as stimulus
// is driven and checked when the strobes appear.
module tb_sc_frame_sng;
    import sc_pkg::*;

    localparam int W     = 6;
    localparam int FRAME = 32;
    localparam int CW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_in;
    logic [W-1:0]  x;
    logic          load;
    logic [W-1:0]  rnd;
    logic          rnd_valid;
    logic          bit_out;
    logic          bit_valid;
    logic          busy;
    logic [CW-1:0] result;
    logic          result_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bit exp_bits[$];
    int exp_results[$];

    sc_frame_sng #(.W(W), .FRAME(FRAME), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_in        (en_in),
        .x            (x),
        .load         (load),
        .rnd          (rnd),
        .rnd_valid    (rnd_valid),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled 1 time unit after each active edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("bit_valid", {31'd0, bit_valid}, {31'd0, exp_bits.size() != 0});
            if (exp_bits.size() != 0) begin
                bit eb;
                eb = exp_bits.pop_front();
                if (bit_valid) chk("bit_out", {31'd0, bit_out}, {31'd0, eb});
            end
            chk("result_valid", {31'd0, result_valid}, {31'd0, exp_results.size() != 0});
            if (exp_results.size() != 0) begin
                int er;
                er = exp_results.pop_front();
                if (result_valid) chk("result", 32'(result), 32'(er));
            end
        end
    end

    task automatic do_load(input int xv);
        x         = W'(xv);
        load      = 1'b1;
        rnd_valid = 1'b0;
        @(negedge clk);
        load = 1'b0;
        chk("busy_after_load", {31'd0, busy}, 32'd1);
    endtask

    // One counted sample; the bit expectation comes from the operand the frame was loaded with.
    task automatic sample(input int xv, input int r, input bit last, input int res);
        rnd       = W'(r);
        rnd_valid = 1'b1;
        exp_bits.push_back(xv > r);
        if (last) exp_results.push_back(res);
        @(negedge clk);
        rnd_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic run_frame(input int xv, input int stride, input int res);
        do_load(xv);
        for (int i = 0; i < FRAME; i++) begin
            sample(xv, i, i == FRAME - 1, res);
            if (i != FRAME - 1) idle_cycles(stride - 1);
        end
    endtask

    initial begin
        rst = 1'b1; en_in = 1'b1; x = '0; load = 1'b0; rnd = '0; rnd_valid = 1'b0;
        idle_cycles(2);
        chk("rst_bit_out", {31'd0, bit_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        idle_cycles(1);

        // Ramp x=16 back-to-back, then probe DONE and IDLE strobes.
        run_frame(16, 1, 16);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        rnd = 6'd0; rnd_valid = 1'b1;
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rnd_valid = 1'b0;
        idle_cycles(1);
        chk("result_hold_idle", 32'(result), 32'd16);

        // Extremes.
        run_frame(0, 1, 0);
        idle_cycles(1);
        run_frame(63, 1, 32);
        idle_cycles(1);

        // Load attempt mid-frame must be ignored.
        do_load(16);
        for (int i = 0; i < FRAME; i++) begin
            if (i == 5) begin
                x = 6'd40; load = 1'b1;
            end
            sample(16, i, i == FRAME - 1, 16);
            load = 1'b0;
            if (i == 6) chk("x_q_stable", 32'(dut.x_q), 32'd16);
        end
        idle_cycles(1);

        // Enable drop mid-frame.
        do_load(63);
        for (int i = 0; i < 5; i++) sample(63, i, 1'b0, 0);
        en_in = 1'b0;
        @(negedge clk);
        en_in = 1'b1;
        chk("en_drop_busy", {31'd0, busy}, 32'd0);
        chk("en_drop_result", 32'(result), 32'd16);
        chk("en_drop_bit_out", {31'd0, bit_out}, 32'd0);
        rnd = 6'd0; rnd_valid = 1'b1;
        @(negedge clk);
        rnd_valid = 1'b0;

        // Load coinciding with enable low stays in IDLE.
        x = 6'd20; load = 1'b1; en_in = 1'b0;
        @(negedge clk);
        load = 1'b0; en_in = 1'b1;
        chk("en_wins_busy", {31'd0, busy}, 32'd0);
        idle_cycles(1);

        // Sparse strobes every third cycle.
        run_frame(16, 3, 16);
        idle_cycles(2);

        // Reset mid-frame, then a fresh x=8 frame.
        do_load(16);
        for (int i = 0; i < 10; i++) sample(16, i, 1'b0, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_bit_valid", {31'd0, bit_valid}, 32'd0);
        chk("mid_rst_bit_out", {31'd0, bit_out}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(1);
        run_frame(8, 1, 8);
        idle_cycles(3);

        chk("sb_bits_drained", 32'(exp_bits.size()), 32'd0);
        chk("sb_results_drained", 32'(exp_results.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
